// File: rtl/mem_pkg.sv
// Shared types and constants for the line-burst memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    WACK  = 2'd3
  } state_t;

  localparam int DEFAULT_LATENCY    = 4;
  localparam int DEFAULT_LINE_WORDS = 4;

  // Width of the beat counter; a one-beat line still needs a 1-bit counter.
  function automatic int beat_idx_w(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (master) and the memory responder (slave).
interface mem_responder_if;

  // Both channels transfer on a rising edge where valid && ready; once raised,
  // a valid and its payload stay stable until that transfer happens.
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_last;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_last
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_data, resp_last
  );

endinterface

// File: rtl/mem_array.sv
// Word storage: synchronous write, combinational read, never cleared.
module mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: single-word writes, critical-word-first line reads.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = DEFAULT_LATENCY,
  parameter int LINE_WORDS  = DEFAULT_LINE_WORDS
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus,
  output state_t         state_dbg
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int BW = beat_idx_w(LINE_WORDS);
  localparam logic [3:0]    LAT_M1    = 4'(LATENCY - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [AW-1:0] LINE_MASK = AW'(LINE_WORDS - 1);

  state_t        state, state_nxt;
  logic [3:0]    lat_cnt, lat_cnt_nxt;
  logic [BW-1:0] beat_cnt, beat_cnt_nxt;

  logic          cap_write;
  logic [AW-1:0] cap_idx;
  logic [31:0]   cap_wdata;

  logic [AW-1:0] req_idx, rd_idx, exp_idx;
  logic [31:0]   rdata, exp_wdata;
  logic          expire, exp_write, mem_we;
  logic          req_ready_c, resp_valid_c, resp_last_c;
  logic [31:0]   resp_data_c;
  logic          unused_addr_bits;

  // Only the word index matters; byte offset and high bits alias silently.
  assign req_idx          = bus.req_addr[AW+1:2];
  assign unused_addr_bits = ^{bus.req_addr[1:0], bus.req_addr[31:AW+2]};

  // Beat address wraps inside the aligned line around the captured word.
  assign rd_idx = (cap_idx & ~LINE_MASK) | ((cap_idx + AW'(beat_cnt)) & LINE_MASK);

  // With LATENCY == 1 the expiry edge is the accept edge, so use the live request.
  assign exp_write = (state == IDLE) ? bus.req_write : cap_write;
  assign exp_idx   = (state == IDLE) ? req_idx       : cap_idx;
  assign exp_wdata = (state == IDLE) ? bus.req_wdata : cap_wdata;
  assign mem_we    = rst && expire && exp_write;

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_mem_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(exp_idx),
    .wdata(exp_wdata),
    .raddr(rd_idx),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lat_cnt  <= lat_cnt_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req_valid) begin
      cap_write <= bus.req_write;
      cap_idx   <= req_idx;
      cap_wdata <= bus.req_wdata;
    end
  end

  always_comb begin
    state_nxt    = state;
    lat_cnt_nxt  = lat_cnt;
    beat_cnt_nxt = beat_cnt;
    expire       = 1'b0;
    req_ready_c  = 1'b0;
    resp_valid_c = 1'b0;
    resp_last_c  = 1'b0;
    resp_data_c  = '0;
    case (state)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          lat_cnt_nxt  = 4'd1;
          beat_cnt_nxt = '0;
          if (LATENCY == 1) begin
            expire    = 1'b1;
            state_nxt = bus.req_write ? WACK : BURST;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (lat_cnt == LAT_M1) begin
          expire      = 1'b1;
          lat_cnt_nxt = '0;
          state_nxt   = cap_write ? WACK : BURST;
        end else begin
          lat_cnt_nxt = lat_cnt + 4'd1;
        end
      end
      BURST: begin
        resp_valid_c = 1'b1;
        resp_data_c  = rdata;
        resp_last_c  = (beat_cnt == LAST_BEAT);
        if (bus.resp_ready) begin
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt_nxt = '0;
            state_nxt    = IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      WACK: begin
        resp_valid_c = 1'b1;
        resp_last_c  = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready  = rst && req_ready_c;
  assign bus.resp_valid = rst && resp_valid_c;
  assign bus.resp_last  = rst && resp_last_c;
  assign bus.resp_data  = rst ? resp_data_c : 32'h0;
  assign state_dbg      = state;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: scoreboarded random/directed traffic on a LATENCY=4
// instance plus a directed back-to-back run on a LATENCY=1 instance.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LINE  = 4;
  localparam int LAT_A = 4;
  localparam int LAT_B = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_responder_if bus_a ();
  mem_responder_if bus_b ();
  state_t state_a, state_b;

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A), .LINE_WORDS(LINE)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .state_dbg(state_a)
  );
  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_B), .LINE_WORDS(LINE)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .state_dbg(state_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] exp_q[$];          // {last, data}
  logic [31:0] ref_mem [DEPTH];
  bit          rand_ready = 1'b0;
  int          stall_beat = -1;
  int          beats_seen = 0;
  int          stall_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired, got no event, expected one", name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- response-ready driver ----------------
  always @(posedge clk) begin
    #1;
    if (stall_beat < 0) stall_done = 0;
    if (stall_beat >= 0 && beats_seen == stall_beat && bus_a.resp_valid && stall_done < 3) begin
      bus_a.resp_ready = 1'b0;
      stall_done++;
    end else if (rand_ready) begin
      bus_a.resp_ready = ($urandom_range(0, 3) != 0);
    end else begin
      bus_a.resp_ready = 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  logic [32:0] mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
      beats_seen = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", bus_a.resp_valid, 1);
        check("stall_data_held", bus_a.resp_data, prev_data);
        check("stall_last_held", bus_a.resp_last, prev_last);
      end
      if (!bus_a.resp_valid) begin
        check("idle_resp_data", bus_a.resp_data, 0);
        check("idle_resp_last", bus_a.resp_last, 0);
      end
      if (bus_a.resp_valid && bus_a.resp_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", bus_a.resp_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", bus_a.resp_data, mon_e[31:0]);
          check("beat_last", bus_a.resp_last, mon_e[32]);
        end
        beats_seen = bus_a.resp_last ? 0 : beats_seen + 1;
      end
      prev_stall = bus_a.resp_valid && !bus_a.resp_ready;
      prev_data  = bus_a.resp_data;
      prev_last  = bus_a.resp_last;
    end
  end

  // ---------------- driver for instance A ----------------
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit abort);
    int  n, idx, base, off;
    bit  done;
    idx = int'(addr[31:2]) % DEPTH;
    @(negedge clk);
    bus_a.req_valid = 1'b1;
    bus_a.req_write = wr;
    bus_a.req_addr  = addr;
    bus_a.req_wdata = wdata;
    n = 0;
    while (!bus_a.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus_a.req_ready) begin
      fail_timeout("accept_wait");
      bus_a.req_valid = 1'b0;
      return;
    end
    if (!abort) begin
      if (wr) begin
        ref_mem[idx] = wdata;
        exp_q.push_back({1'b1, 32'h0});
      end else begin
        base = idx - (idx % LINE);
        off  = idx % LINE;
        for (int i = 0; i < LINE; i++)
          exp_q.push_back({(i == LINE - 1), ref_mem[base + ((off + i) % LINE)]});
      end
    end
    @(posedge clk);
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    if (abort) begin
      check("abort_in_wait", state_a, WAIT);
      rst = 1'b0;
      @(negedge clk);
      check("rst_req_ready", bus_a.req_ready, 0);
      check("rst_resp_valid", bus_a.resp_valid, 0);
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        check("abort_no_beat", bus_a.resp_valid, 0);
      end
      return;
    end
    n = 1;
    while (!bus_a.resp_valid && n < 40) begin
      check("busy_req_ready", bus_a.req_ready, 0);
      @(negedge clk);
      n++;
    end
    check("first_beat_latency", n, LAT_A);
    done = 1'b0;
    n = 0;
    while (!done && n < 300) begin
      check("busy_req_ready", bus_a.req_ready, 0);
      if (bus_a.resp_valid && bus_a.resp_ready && bus_a.resp_last) done = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (!done) fail_timeout("burst_end");
    else begin
      @(negedge clk);
      check("done_req_ready", bus_a.req_ready, 1);
      check("done_state", state_a, IDLE);
    end
  endtask

  // ---------------- directed back-to-back run on instance B ----------------
  task automatic run_b();
    logic [31:0] bmem [LINE];
    logic [31:0] addr;
    bit          wr;
    int          idx;
    @(negedge clk);
    for (int t = 0; t < LINE + 2; t++) begin
      wr   = (t < LINE);
      addr = wr ? 32'(t * 4) : ((t == LINE) ? 32'h8 : 32'h4);
      check("b_req_ready", bus_b.req_ready, 1);
      bus_b.req_valid = 1'b1;
      bus_b.req_write = wr;
      bus_b.req_addr  = addr;
      bus_b.req_wdata = $urandom();
      idx = int'(addr[31:2]) % LINE;
      if (wr) bmem[idx] = bus_b.req_wdata;
      @(posedge clk);
      if (wr) begin
        @(negedge clk);
        check("b_ack_valid", bus_b.resp_valid, 1);
        check("b_ack_data", bus_b.resp_data, 0);
        check("b_ack_last", bus_b.resp_last, 1);
      end else begin
        for (int i = 0; i < LINE; i++) begin
          @(negedge clk);
          check("b_beat_valid", bus_b.resp_valid, 1);
          check("b_beat_data", bus_b.resp_data, bmem[(idx + i) % LINE]);
          check("b_beat_last", bus_b.resp_last, (i == LINE - 1));
          check("b_busy_ready", bus_b.req_ready, 0);
        end
      end
      @(negedge clk);
    end
    check("b_req_ready_end", bus_b.req_ready, 1);
    bus_b.req_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] addr;
    rst = 1'b0;
    bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
    bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
    bus_b.resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_req_ready", bus_a.req_ready, 0);
    check("reset_resp_valid", bus_a.resp_valid, 0);
    check("reset_resp_data", bus_a.resp_data, 0);
    check("reset_resp_last", bus_a.resp_last, 0);
    check("reset_state", state_a, IDLE);
    check("reset_b_req_ready", bus_b.req_ready, 0);
    check("reset_b_state", state_b, IDLE);
    rst = 1'b1;
    #1;
    check("post_reset_req_ready", bus_a.req_ready, 1);

    // preload the address window used by every later access
    rand_ready = 1'b1;
    for (int i = 0; i < 64; i++) do_req(1'b1, 32'(i * 4), $urandom(), 1'b0);

    // basic write then line read with ready held high
    rand_ready = 1'b0;
    do_req(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0);
    do_req(1'b0, 32'h40, 32'h0, 1'b0);

    // wrap within the line
    for (int i = 0; i < 4; i++) do_req(1'b1, 32'h50 + 32'(i * 4), 32'(i + 1), 1'b0);
    do_req(1'b0, 32'h58, 32'h0, 1'b0);

    // aliasing of high address bits and byte offset
    do_req(1'b0, 32'h1000_0040, 32'h0, 1'b0);
    do_req(1'b1, 32'h2000_0047, 32'hCAFE_F00D, 1'b0);
    do_req(1'b0, 32'h44, 32'h0, 1'b0);

    // stall the second beat for three cycles
    stall_beat = 1;
    do_req(1'b0, 32'h60, 32'h0, 1'b0);
    check("stall_applied", stall_done, 3);
    stall_beat = -1;

    // reset during the latency wait of a write
    do_req(1'b1, 32'h80, 32'hAA, 1'b0);
    do_req(1'b1, 32'h80, 32'h1234_5678, 1'b1);
    do_req(1'b0, 32'h80, 32'h0, 1'b0);

    // random traffic with random back-pressure
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      addr = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 63) << 2) | 32'($urandom_range(0, 3));
      do_req(1'($urandom_range(0, 1)), addr, $urandom(), 1'b0);
    end
    rand_ready = 1'b0;

    run_b();

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
